// File: rtl/core_pkg.sv
// Shared decode definitions for the 8-bit core: opcodes, instruction field
// positions and register address width.
package core_pkg;

  localparam int REG_AW = 3;
  localparam int DATA_W = 8;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 9;
  localparam int RS1_MSB = 8;
  localparam int RS1_LSB = 6;
  localparam int RS2_MSB = 5;
  localparam int RS2_LSB = 3;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_LDI = 4'd6;
  localparam logic [3:0] OP_LD  = 4'd7;
  localparam logic [3:0] OP_ST  = 4'd8;

  // Unused encodings and empty IF/ID slots both collapse to NOP.
  function automatic logic [3:0] norm_op(input logic [3:0] raw, input logic valid);
    return (valid && raw <= OP_ST) ? raw : OP_NOP;
  endfunction

  function automatic logic is_alu(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_XOR);
  endfunction

  function automatic logic uses_rs1(input logic [3:0] op);
    return is_alu(op) || (op == OP_LD) || (op == OP_ST);
  endfunction

  function automatic logic uses_rs2(input logic [3:0] op);
    return is_alu(op) || (op == OP_ST);
  endfunction

endpackage

// File: rtl/id_issue_ctrl_if.sv
// ID/EX producer bus: decoded operands, source indices and pipeline control.
interface id_issue_ctrl_if;
  import core_pkg::*;

  logic [3:0]        opcode_out;
  logic [DATA_W-1:0] A_out;
  logic [DATA_W-1:0] B_out;
  logic [REG_AW-1:0] rd_out;
  logic [REG_AW-1:0] rs1_out;
  logic [REG_AW-1:0] rs2_out;
  logic              stall;
  logic              ifid_hold;

  modport master (
    output opcode_out, A_out, B_out, rd_out, rs1_out, rs2_out, stall, ifid_hold
  );

  modport slave (
    input opcode_out, A_out, B_out, rd_out, rs1_out, rs2_out, stall, ifid_hold
  );
endinterface

// File: rtl/id_issue_ctrl_regfile_8x8.sv
// 2R1W register file, R0 hardwired to zero, write-first bypass on reads.
module regfile_8x8
  import core_pkg::*;
#(
  parameter int unsigned NREGS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [DATA_W-1:0] wd
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && wa != '0) begin
      regs[wa] <= wd;
    end
  end

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (ra1 != '0) rd1 = (we && wa == ra1) ? wd : regs[ra1];
    if (ra2 != '0) rd2 = (we && wa == ra2) ? wd : regs[ra2];
  end

endmodule

// File: rtl/id_issue_ctrl.sv
// ID-stage decode/issue: field split, operand read, load-use stall generation
// and IF/ID hold. Outputs are combinational; ID/EX provides the register.
module id_issue_ctrl
  import core_pkg::*;
#(
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned NREGS    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           instr,
  input  logic                  instr_valid,
  input  logic                  flush,
  input  logic                  wb_en,
  input  logic [REG_AW-1:0]     wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  id_issue_ctrl_if.master       idex
);

  localparam logic [1:0] CNT_INIT = 2'(LOAD_LAT - 1);

  logic [3:0]        op;
  logic [REG_AW-1:0] rd, rs1, rs2;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] r1_data, r2_data;

  logic [1:0]        cnt, cnt_n;
  logic              last_ld, last_ld_n;
  logic [REG_AW-1:0] last_rd, last_rd_n;

  logic              hazard;
  logic              stall_c, hold_c;
  logic [3:0]        opc_c;
  logic [DATA_W-1:0] a_c, b_c;
  logic [REG_AW-1:0] rd_c, rs1_c, rs2_c;

  regfile_8x8 #(.NREGS(NREGS)) u_rf (
    .clk (clk),
    .rst (rst),
    .ra1 (rs1),
    .ra2 (rs2),
    .rd1 (r1_data),
    .rd2 (r2_data),
    .we  (wb_en),
    .wa  (wb_addr),
    .wd  (wb_data)
  );

  always_comb begin
    op  = norm_op(instr[OPC_MSB:OPC_LSB], instr_valid);
    rd  = instr[RD_MSB:RD_LSB];
    rs1 = instr[RS1_MSB:RS1_LSB];
    rs2 = instr[RS2_MSB:RS2_LSB];
    imm = instr[IMM_MSB:IMM_LSB];

    hazard = last_ld && (last_rd != '0) &&
             ((uses_rs1(op) && rs1 == last_rd) || (uses_rs2(op) && rs2 == last_rd));

    a_c   = (op == OP_NOP || op == OP_LDI) ? '0 : r1_data;
    b_c   = (is_alu(op) || op == OP_ST) ? r2_data : (op == OP_LDI) ? imm : '0;
    rd_c  = (is_alu(op) || op == OP_LDI || op == OP_LD) ? rd : '0;
    rs1_c = uses_rs1(op) ? rs1 : '0;
    rs2_c = uses_rs2(op) ? rs2 : '0;
    opc_c = op;

    stall_c = 1'b0;
    hold_c  = 1'b0;
    cnt_n   = cnt;
    if (flush) begin
      cnt_n = '0;
      opc_c = OP_NOP;
    end else if (cnt != '0) begin
      stall_c = 1'b1;
      hold_c  = 1'b1;
      cnt_n   = cnt - 2'd1;
    end else if (hazard) begin
      stall_c = 1'b1;
      hold_c  = 1'b1;
      cnt_n   = CNT_INIT;
    end

    // Tracker follows what ID/EX actually accepts; bubbles never look like loads.
    last_ld_n = !flush && !stall_c && (op == OP_LD);
    last_rd_n = (flush || stall_c) ? '0 : rd_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      last_ld <= 1'b0;
      last_rd <= '0;
    end else begin
      cnt     <= cnt_n;
      last_ld <= last_ld_n;
      last_rd <= last_rd_n;
    end
  end

  always_comb begin
    idex.opcode_out = rst ? '0 : opc_c;
    idex.A_out      = rst ? '0 : a_c;
    idex.B_out      = rst ? '0 : b_c;
    idex.rd_out     = rst ? '0 : rd_c;
    idex.rs1_out    = rst ? '0 : rs1_c;
    idex.rs2_out    = rst ? '0 : rs2_c;
    idex.stall      = rst ? 1'b0 : stall_c;
    idex.ifid_hold  = rst ? 1'b0 : hold_c;
  end

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Directed bench for id_issue_ctrl: two instances (LOAD_LAT=1 and 3) share stimulus.
module tb_id_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr;
  logic        instr_valid;
  logic        flush;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [7:0]  wb_data;

  int total = 0;
  int bad   = 0;

  id_issue_ctrl_if ia();
  id_issue_ctrl_if ib();

  id_issue_ctrl #(.LOAD_LAT(1), .NREGS(8)) dut_a (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .flush(flush),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .idex(ia)
  );

  id_issue_ctrl #(.LOAD_LAT(3), .NREGS(8)) dut_b (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .flush(flush),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .idex(ib)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] r3(input logic [3:0] op, input logic [2:0] d,
                                     input logic [2:0] s1, input logic [2:0] s2);
    return {op, d, s1, s2, 3'b000};
  endfunction

  function automatic logic [15:0] ldi(input logic [2:0] d, input logic [7:0] imm);
    return {4'd6, d, 1'b0, imm};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chka(input string tag, input logic [3:0] opc, input logic [7:0] a,
                      input logic [7:0] b, input logic [2:0] d, input logic st);
    chk({tag, ".opc"},   8'(ia.opcode_out), 8'(opc));
    chk({tag, ".A"},     ia.A_out, a);
    chk({tag, ".B"},     ia.B_out, b);
    chk({tag, ".rd"},    8'(ia.rd_out), 8'(d));
    chk({tag, ".stall"}, 8'(ia.stall), 8'(st));
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; instr = r3(4'd1, 3'd3, 3'd2, 3'd2); instr_valid = 1'b1;
    flush = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    settle();
    chka("reset", 4'd0, 8'h00, 8'h00, 3'd0, 1'b0);
    chk("reset.rs1", 8'(ia.rs1_out), 8'h0);
    chk("reset.rs2", 8'(ia.rs2_out), 8'h0);
    chk("reset.hold", 8'(ia.ifid_hold), 8'h0);
    chk("reset.b_stall", 8'(ib.stall), 8'h0);
    adv();

    rst = 1'b0; instr = ldi(3'd1, 8'h5A); wb_en = 1'b1; wb_addr = 3'd1; wb_data = 8'h5A;
    settle();
    chka("ldi", 4'd6, 8'h00, 8'h5A, 3'd1, 1'b0);
    adv();

    wb_addr = 3'd2; wb_data = 8'h33; instr = r3(4'd1, 3'd3, 3'd2, 3'd2);
    settle();
    chka("bypass", 4'd1, 8'h33, 8'h33, 3'd3, 1'b0);
    chk("bypass.rs1", 8'(ia.rs1_out), 8'h2);
    chk("bypass.rs2", 8'(ia.rs2_out), 8'h2);
    adv();

    wb_addr = 3'd0; wb_data = 8'hFF; instr = r3(4'd1, 3'd6, 3'd0, 3'd2);
    settle();
    chka("r0_wr_same", 4'd1, 8'h00, 8'h33, 3'd6, 1'b0);
    adv();

    wb_en = 1'b0; instr = r3(4'd1, 3'd6, 3'd0, 3'd0);
    settle();
    chka("r0_after", 4'd1, 8'h00, 8'h00, 3'd6, 1'b0);
    adv();

    instr = r3(4'd7, 3'd4, 3'd1, 3'd0);
    settle();
    chka("ld", 4'd7, 8'h5A, 8'h00, 3'd4, 1'b0);
    chk("ld.b_stall", 8'(ib.stall), 8'h0);
    adv();

    instr = r3(4'd1, 3'd5, 3'd4, 3'd1);
    settle();
    chk("lu1.a_stall", 8'(ia.stall), 8'h1);
    chk("lu1.a_hold", 8'(ia.ifid_hold), 8'h1);
    chk("lu1.b_stall_c1", 8'(ib.stall), 8'h1);
    adv();
    settle();
    chka("lu1.reissue", 4'd1, 8'h00, 8'h5A, 3'd5, 1'b0);
    chk("lu3.b_stall_c2", 8'(ib.stall), 8'h1);
    adv();
    settle();
    chk("lu3.b_stall_c3", 8'(ib.stall), 8'h1);
    chk("lu3.b_hold_c3", 8'(ib.ifid_hold), 8'h1);
    adv();
    settle();
    chk("lu3.b_issue", 8'(ib.stall), 8'h0);
    chk("lu3.b_opc", 8'(ib.opcode_out), 8'h1);
    adv();

    instr = r3(4'd7, 3'd4, 3'd1, 3'd0);
    adv();
    instr = r3(4'd1, 3'd5, 3'd1, 3'd2);
    settle();
    chka("nohaz", 4'd1, 8'h5A, 8'h33, 3'd5, 1'b0);
    chk("nohaz.b_stall", 8'(ib.stall), 8'h0);
    adv();

    instr = r3(4'd7, 3'd0, 3'd1, 3'd0);
    settle();
    chk("ld_r0.rd", 8'(ia.rd_out), 8'h0);
    adv();
    instr = r3(4'd1, 3'd6, 3'd0, 3'd0);
    settle();
    chk("r0haz.a_stall", 8'(ia.stall), 8'h0);
    chk("r0haz.b_stall", 8'(ib.stall), 8'h0);
    adv();

    instr = r3(4'd7, 3'd4, 3'd1, 3'd0); wb_en = 1'b1; wb_addr = 3'd4; wb_data = 8'h44;
    adv();
    wb_en = 1'b0; instr = r3(4'd8, 3'd0, 3'd1, 3'd4);
    settle();
    chk("st.a_stall", 8'(ia.stall), 8'h1);
    chk("st.b_stall_c1", 8'(ib.stall), 8'h1);
    adv();
    settle();
    chka("st.issue", 4'd8, 8'h5A, 8'h44, 3'd0, 1'b0);
    chk("st.b_stall_c2", 8'(ib.stall), 8'h1);
    adv();
    flush = 1'b1;
    settle();
    chk("flush.b_stall", 8'(ib.stall), 8'h0);
    chk("flush.b_hold", 8'(ib.ifid_hold), 8'h0);
    chk("flush.b_opc", 8'(ib.opcode_out), 8'h0);
    chk("flush.a_opc", 8'(ia.opcode_out), 8'h0);
    adv();
    flush = 1'b0; instr = r3(4'd1, 3'd5, 3'd4, 3'd1);
    settle();
    chk("postflush.b_stall", 8'(ib.stall), 8'h0);
    chk("postflush.b_opc", 8'(ib.opcode_out), 8'h1);
    chk("postflush.b_A", ib.A_out, 8'h44);
    chk("postflush.b_B", ib.B_out, 8'h5A);
    adv();

    instr = r3(4'd7, 3'd4, 3'd1, 3'd0);
    adv();
    instr = r3(4'd1, 3'd5, 3'd4, 3'd4);
    settle();
    chk("rstmid.b_stall", 8'(ib.stall), 8'h1);
    adv();
    rst = 1'b1;
    settle();
    chk("rstmid.opc", 8'(ib.opcode_out), 8'h0);
    chk("rstmid.A", ib.A_out, 8'h00);
    chk("rstmid.B", ib.B_out, 8'h00);
    chk("rstmid.rd", 8'(ib.rd_out), 8'h0);
    chk("rstmid.stall", 8'(ib.stall), 8'h0);
    chk("rstmid.hold", 8'(ib.ifid_hold), 8'h0);
    adv();
    rst = 1'b0;
    settle();
    chk("postrst.b_stall", 8'(ib.stall), 8'h0);
    chk("postrst.b_opc", 8'(ib.opcode_out), 8'h1);
    chk("postrst.b_A", ib.A_out, 8'h00);
    chka("postrst.a", 4'd1, 8'h00, 8'h00, 3'd5, 1'b0);
    adv();

    instr_valid = 1'b0; instr = r3(4'd1, 3'd5, 3'd1, 3'd1);
    settle();
    chka("invalid", 4'd0, 8'h00, 8'h00, 3'd0, 1'b0);
    chk("invalid.rs1", 8'(ia.rs1_out), 8'h0);
    adv();
    instr_valid = 1'b1; instr = r3(4'd7, 3'd4, 3'd1, 3'd0);
    adv();
    instr_valid = 1'b0; instr = r3(4'd1, 3'd5, 3'd4, 3'd4);
    settle();
    chk("inv_after_ld.a", 8'(ia.stall), 8'h0);
    chk("inv_after_ld.b", 8'(ib.stall), 8'h0);
    adv();
    instr_valid = 1'b1; instr = r3(4'd9, 3'd5, 3'd4, 3'd4);
    settle();
    chka("op9", 4'd0, 8'h00, 8'h00, 3'd0, 1'b0);
    adv();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
